dac_sample_feeder: RTL and testbench
====================================

Name: dac_sample_feeder

Overview:
Upstream neighbour of the DAC PHY. Accepts signed 12-bit I/Q sample pairs from the sound-generation pipeline over a valid/ready stream, buffers them in a small FIFO, and releases one pair every RATE cycles. Output is converted to offset binary and presented as registered data_i/data_q for the DAC PHY. Handles start-up prefill, underflow hold and underflow statistics.

Parameters:
DEPTH, 16, FIFO depth in sample pairs (power of two, 4..256)
PREFILL, 8, FIFO level required before playback starts (1..DEPTH)
DIV_W, 16, width of rate_div

Ports:
phy_clk  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  playback enable; low = flush and idle
rate_div  in  DIV_W  output period minus 1, in phy_clk cycles
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid&&s_ready
s_data_i  in  12  I sample, two's complement
s_data_q  in  12  Q sample, two's complement
clr_underflow  in  1  single-cycle pulse; clears underflow flag and counter
data_i  out  12  I sample to DAC PHY, offset binary, registered
data_q  out  12  Q sample to DAC PHY, offset binary, registered
sample_strobe  out  1  one-cycle pulse when data_i/data_q take a new popped value
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
running  out  1  high in RUN state
underflow  out  1  sticky underflow flag
underflow_cnt  out  16  saturating underflow count

Behaviour:
- Clock phy_clk; reset synchronous, active-high. Reset values: data_i=data_q=12'h800, sample_strobe=0, fifo_level=0, running=0, underflow=0, underflow_cnt=0, state=IDLE, divider count=0.
- s_ready = enable && (fifo_level < DEPTH), combinational from registered state. A push is accepted only when full is false at that cycle; a pop in the same cycle does not free space for that cycle's push.
- Offset-binary conversion: out = {~in[11], in[10:0]}; for example, 12'h000 -> 12'h800, 12'h7FF -> 12'hFFF, 12'h800 -> 12'h000.
- States:
  - IDLE: entered on reset or whenever enable=0, from any state, in the next cycle.
    - FIFO flushed: level=0, pointers=0. Pushes are blocked.
    - data_i/data_q forced to 12'h800. Divider held at 0.
    - enable=1 -> PRIME.
  - PRIME: pushes accepted, no pops, outputs hold their current value. fifo_level >= PREFILL -> RUN, divider count reset to 0.
  - RUN: running=1.
    - Divider counts 0,1,...; tick when count >= rate_div, then count returns to 0. rate_div=0 gives a tick every cycle.
    - rate_div changes take effect immediately. If count already exceeds the new value, tick on the next cycle.
- Tick in cycle T with FIFO non-empty:
  - Pop the head entry.
  - data_i/data_q are updated and sample_strobe=1 in cycle T+1, so latency from tick is 1 cycle.
- Tick in cycle T with FIFO empty (underflow):
  - No pop, outputs hold the last value, sample_strobe stays 0.
  - underflow set to 1; underflow_cnt increments, saturating at 16'hFFFF.
  - State stays RUN. A push in cycle T is not poppable until the next tick.
- Push and pop in the same cycle: level unchanged, both operations performed.
- Push into an empty FIFO coincident with a tick counts as underflow; the data is retained.
- clr_underflow clears underflow and underflow_cnt. If it coincides with a new underflow event, the result is underflow=1, underflow_cnt=1.
- FIFO order is strict first-in-first-out; pointers wrap modulo DEPTH. The FIFO never overwrites and never pops from empty.
- Reset asserted mid-operation returns all state to the reset values on the next edge, regardless of enable.

Test Plan:
1. Reset, enable=1, push 8 pairs I=n, Q=-n (n=1..8), rate_div=3 -> running rises after the 8th push. data_i sequence is 12'h801, 12'h802, ...; data_q is 12'h7FF, 12'h7FE, .... sample_strobe fires every 4 cycles, 1 cycle after each tick.
2. Prefill 8, no further pushes, rate_div=0 -> 8 strobes on consecutive cycles. Outputs then hold I=12'h808. underflow=1 and underflow_cnt increments every cycle, reaching 5 after 5 more cycles.
3. Push continuously with s_valid=1 and rate_div=9 -> fifo_level reaches 16 and s_ready=0. No data is lost or duplicated: a scoreboard matches 100 samples in order.
4. Mid-RUN, drop enable -> next cycle state is IDLE, data_i=data_q=12'h800, fifo_level=0, running=0, s_ready=0. Re-enable -> PRIME waits for 8 new pushes.
5. Boundary values: push I=12'h7FF, Q=12'h800 -> data_i=12'hFFF, data_q=12'h000. Then, during an underflow, pulse clr_underflow on a tick cycle -> underflow_cnt=1, underflow=1.
6. Preload underflow_cnt to 16'hFFFF by forcing or a long starvation run -> it stays 16'hFFFF. Assert reset mid-stream -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder
// Sits directly upstream of the DAC PHY. Signed 12-bit I/Q pairs arrive on a
// valid/ready stream and are buffered in a small FIFO. Once enough samples are
// queued (prefill), one pair is released every rate_div+1 cycles, converted to
// offset binary and presented on registered outputs. Starvation is counted
// rather than glitching the output: the last value is held.
//
// Ports:
//   phy_clk        clock
//   reset          synchronous, active-high reset
//   enable         playback enable; low flushes the FIFO and idles
//   rate_div       output period minus one, in phy_clk cycles
//   s_valid        input pair valid
//   s_ready        input pair accepted when s_valid && s_ready
//   s_data_i/q     input I/Q samples, two's complement
//   clr_underflow  pulse clearing the underflow flag and counter
//   data_i/q       output I/Q samples to the PHY, offset binary, registered
//   sample_strobe  one-cycle pulse when data_i/q take a newly popped value
//   fifo_level     current FIFO occupancy
//   running        high while playing out samples
//   underflow      sticky flag, set when a tick finds the FIFO empty
//   underflow_cnt  saturating count of underflow events

module dac_sample_feeder #(
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8,
    parameter int DIV_W   = 16
) (
    input  logic                     phy_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [11:0]              s_data_i,
    input  logic [11:0]              s_data_q,
    input  logic                     clr_underflow,
    output logic [11:0]              data_i,
    output logic [11:0]              data_q,
    output logic                     sample_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     running,
    output logic                     underflow,
    output logic [15:0]              underflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
    localparam logic [11:0]   MIDSCALE  = 12'h800;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t           state;
    logic [23:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [DIV_W-1:0] div_cnt;
    logic             push;
    logic             pop;
    logic             tick;
    logic             empty;
    logic             uf_event;

    // Two's complement to offset binary is just an MSB flip.
    function automatic logic [11:0] to_offset(input logic [11:0] v);
        return {~v[11], v[10:0]};
    endfunction

    // Readiness depends only on registered occupancy, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign s_ready  = enable && (fifo_level < DEPTH_L);
    assign push     = s_valid && s_ready;
    assign empty    = (fifo_level == '0);
    // The divider compares against the live rate_div so a new value applies
    // at once; a count already past it ticks on the next comparison.
    assign tick     = (state == RUN) && enable && (div_cnt >= rate_div);
    assign pop      = tick && !empty;
    assign uf_event = tick && empty;

    // Sample storage; pointers and occupancy define what is valid, so the
    // array itself needs no reset.
    always_ff @(posedge phy_clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_data_i, s_data_q};
        end
    end

    // Playback state machine, FIFO bookkeeping, rate divider and output
    // registers. Dropping enable flushes everything back to IDLE in one cycle.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state         <= IDLE;
            running       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            div_cnt       <= '0;
            data_i        <= MIDSCALE;
            data_q        <= MIDSCALE;
            sample_strobe <= 1'b0;
        end else if (!enable) begin
            state         <= IDLE;
            running       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            div_cnt       <= '0;
            data_i        <= MIDSCALE;
            data_q        <= MIDSCALE;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                data_i        <= to_offset(mem[rd_ptr][23:12]);
                data_q        <= to_offset(mem[rd_ptr][11:0]);
                sample_strobe <= 1'b1;
            end

            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase

            unique case (state)
                IDLE: begin
                    state   <= PRIME;
                    running <= 1'b0;
                    div_cnt <= '0;
                end
                PRIME: begin
                    div_cnt <= '0;
                    if (fifo_level >= PREFILL_L) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    running <= 1'b1;
                    if (tick) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    div_cnt <= '0;
                end
            endcase
        end
    end

    // Underflow statistics survive enable toggling; only reset or an
    // explicit clear wipes them. A clear that lands on a fresh underflow
    // keeps that one event.
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else if (clr_underflow) begin
            underflow     <= uf_event;
            underflow_cnt <= uf_event ? 16'd1 : 16'd0;
        end else if (uf_event) begin
            underflow <= 1'b1;
            if (underflow_cnt != 16'hFFFF) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Testbench for dac_sample_feeder. A queue-based reference model advances on
// every rising edge; scenario tasks drive stimulus on the falling edge and
// compare DUT outputs against the model and against known constant values.

module tb_dac_sample_feeder;

    localparam int DEPTH   = 16;
    localparam int PREFILL = 8;
    localparam int DIV_W   = 16;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int VW      = 43 + LW;

    logic              phy_clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  rate_div = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [11:0]       s_data_i = '0;
    logic [11:0]       s_data_q = '0;
    logic              clr_underflow = 1'b0;
    logic [11:0]       data_i;
    logic [11:0]       data_q;
    logic              sample_strobe;
    logic [LW-1:0]     fifo_level;
    logic              running;
    logic              underflow;
    logic [15:0]       underflow_cnt;
    logic [VW-1:0]     dut_vec;

    int checks = 0;
    int errors = 0;

    dac_sample_feeder #(
        .DEPTH(DEPTH),
        .PREFILL(PREFILL),
        .DIV_W(DIV_W)
    ) dut (
        .phy_clk(phy_clk),
        .reset(reset),
        .enable(enable),
        .rate_div(rate_div),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data_i(s_data_i),
        .s_data_q(s_data_q),
        .clr_underflow(clr_underflow),
        .data_i(data_i),
        .data_q(data_q),
        .sample_strobe(sample_strobe),
        .fifo_level(fifo_level),
        .running(running),
        .underflow(underflow),
        .underflow_cnt(underflow_cnt)
    );

    // 10-unit clock period
    always #5 phy_clk = ~phy_clk;

    assign dut_vec = {data_i, data_q, sample_strobe, fifo_level, running, underflow, underflow_cnt};

    // Reference model state: the FIFO is a plain queue of {I,Q} pairs.
    typedef enum {STOPPED, FILLING, PLAYING} mode_t;
    logic [23:0] mq[$];
    mode_t       m_mode = STOPPED;
    int          m_cnt = 0;
    logic [11:0] m_di = 12'h800;
    logic [11:0] m_dq = 12'h800;
    logic        m_strobe = 1'b0;
    logic        m_uf = 1'b0;
    int          m_ufc = 0;

    function automatic logic [11:0] ob(input logic [11:0] v);
        return v ^ 12'h800;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_di, m_dq, m_strobe, LW'(mq.size()), (m_mode == PLAYING), m_uf, 16'(m_ufc)};
    endfunction

    function automatic logic model_ready();
        return enable && (mq.size() < DEPTH);
    endfunction

    // Advance the model by one rising edge using the inputs held over it.
    task automatic model_edge();
        logic        accept;
        logic        starve;
        logic [23:0] head;
        accept   = s_valid && enable && (mq.size() < DEPTH);
        starve   = 1'b0;
        m_strobe = 1'b0;
        if (reset) begin
            mq.delete();
            m_mode = STOPPED;
            m_cnt  = 0;
            m_di   = 12'h800;
            m_dq   = 12'h800;
            m_uf   = 1'b0;
            m_ufc  = 0;
            return;
        end
        if (!enable) begin
            mq.delete();
            m_mode = STOPPED;
            m_cnt  = 0;
            m_di   = 12'h800;
            m_dq   = 12'h800;
        end else begin
            case (m_mode)
                STOPPED: m_mode = FILLING;
                FILLING: begin
                    if (mq.size() >= PREFILL) begin
                        m_mode = PLAYING;
                        m_cnt  = 0;
                    end
                end
                default: begin
                    if (m_cnt >= int'(rate_div)) begin
                        m_cnt = 0;
                        if (mq.size() > 0) begin
                            head     = mq.pop_front();
                            m_di     = ob(head[23:12]);
                            m_dq     = ob(head[11:0]);
                            m_strobe = 1'b1;
                        end else begin
                            starve = 1'b1;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
            if (accept) mq.push_back({s_data_i, s_data_q});
        end
        if (clr_underflow) begin
            m_uf  = starve;
            m_ufc = starve ? 1 : 0;
        end else if (starve) begin
            m_uf = 1'b1;
            if (m_ufc < 65535) m_ufc++;
        end
    endtask

    task automatic cycle();
        @(posedge phy_clk);
        model_edge();
        @(negedge phy_clk);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        s_valid = 1'b0;
        clr_underflow = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        checks++;
        if (dut_vec !== {12'h800, 12'h800, 1'b0, LW'(0), 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h, expected %h", dut_vec, {12'h800, 12'h800, 1'b0, LW'(0), 1'b0, 1'b0, 16'd0});
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("[TB] FAIL reset_model: got %h, expected %h", dut_vec, model_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_prefill_playback();
        int k = 0;
        int last = 0;
        enable = 1'b1;
        rate_div = 16'd3;
        for (int n = 1; n <= 8; n++) begin
            s_valid = 1'b1;
            s_data_i = 12'(n);
            s_data_q = 12'(-n);
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("[TB] FAIL prefill_push: got %h, expected %h", dut_vec, model_vec());
            end
        end
        s_valid = 1'b0;
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL running_before_prefill: got %b, expected 0", running);
        end
        cycle();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL running_after_prefill: got %b, expected 1", running);
        end
        for (int cyc = 1; cyc <= 60 && k < 8; cyc++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("[TB] FAIL playback_model: got %h, expected %h", dut_vec, model_vec());
            end
            if (sample_strobe === 1'b1) begin
                k++;
                checks++;
                if (data_i !== 12'(12'h800 + k) || data_q !== 12'(12'h800 - k)) begin
                    errors++;
                    $display("[TB] FAIL playback_data: got %h/%h, expected %h/%h", data_i, data_q, 12'(12'h800 + k), 12'(12'h800 - k));
                end
                if (k > 1) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++;
                        $display("[TB] FAIL strobe_spacing: got %0d, expected 4", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        checks++;
        if (k != 8) begin
            errors++;
            $display("[TB] FAIL playback_count: got %0d strobes, expected 8", k);
        end
    endtask

    task automatic test_underflow_run();
        int waited = 0;
        reset_pulse();
        enable = 1'b1;
        rate_div = 16'd0;
        for (int n = 1; n <= 8; n++) begin
            s_valid = 1'b1;
            s_data_i = 12'(n);
            s_data_q = 12'($urandom);
            cycle();
        end
        s_valid = 1'b0;
        while (sample_strobe !== 1'b1 && waited < 10) begin
            cycle();
            waited++;
        end
        checks++;
        if (sample_strobe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_strobe_timeout: got %b, expected 1", sample_strobe);
        end
        for (int i = 0; i < 7; i++) begin
            cycle();
            checks++;
            if (sample_strobe !== 1'b1 || dut_vec !== model_vec()) begin
                errors++;
                $display("[TB] FAIL back_to_back_strobe: got %h, expected %h", dut_vec, model_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("[TB] FAIL starve_model: got %h, expected %h", dut_vec, model_vec());
            end
        end
        checks++;
        if (underflow_cnt !== 16'd5 || underflow !== 1'b1 || data_i !== 12'h808) begin
            errors++;
            $display("[TB] FAIL starve_count: got cnt=%0d uf=%b i=%h, expected cnt=5 uf=1 i=808", underflow_cnt, underflow, data_i);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] sb[$];
        logic [23:0] want;
        int got = 0;
        logic saw_full = 1'b0;
        reset_pulse();
        enable = 1'b1;
        rate_div = 16'd9;
        s_valid = 1'b1;
        for (int cyc = 0; cyc < 1400 && got < 100; cyc++) begin
            s_data_i = 12'($urandom);
            s_data_q = 12'($urandom);
            #1;
            checks++;
            if (s_ready !== model_ready()) begin
                errors++;
                $display("[TB] FAIL bp_ready: got %b, expected %b", s_ready, model_ready());
            end
            if (mq.size() < DEPTH) sb.push_back({s_data_i, s_data_q});
            if (fifo_level === LW'(DEPTH) && s_ready === 1'b0) saw_full = 1'b1;
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("[TB] FAIL bp_model: got %h, expected %h", dut_vec, model_vec());
            end
            if (sample_strobe === 1'b1) begin
                got++;
                want = (sb.size() > 0) ? sb.pop_front() : 24'h0;
                checks++;
                if (data_i !== ob(want[23:12]) || data_q !== ob(want[11:0])) begin
                    errors++;
                    $display("[TB] FAIL bp_scoreboard: got %h/%h, expected %h/%h", data_i, data_q, ob(want[23:12]), ob(want[11:0]));
                end
            end
        end
        s_valid = 1'b0;
        checks++;
        if (got != 100 || saw_full !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_summary: got samples=%0d full=%b uf=%b, expected 100/1/0", got, saw_full, underflow);
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_ready_comb: got %b, expected 0", s_ready);
        end
        cycle();
        checks++;
        if ({data_i, data_q, fifo_level, running, s_ready} !== {12'h800, 12'h800, LW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL drop_idle: got %h, expected %h", {data_i, data_q, fifo_level, running, s_ready}, {12'h800, 12'h800, LW'(0), 1'b0, 1'b0});
        end
        enable = 1'b1;
        cycle();
        for (int n = 0; n < 7; n++) begin
            s_valid = 1'b1;
            s_data_i = 12'($urandom);
            s_data_q = 12'($urandom);
            cycle();
        end
        s_valid = 1'b0;
        for (int n = 0; n < 3; n++) cycle();
        checks++;
        if (running !== 1'b0 || dut_vec !== model_vec()) begin
            errors++;
            $display("[TB] FAIL reprime_wait: got %h, expected %h", dut_vec, model_vec());
        end
        s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
        cycle();
        checks++;
        if (running !== 1'b1 || dut_vec !== model_vec()) begin
            errors++;
            $display("[TB] FAIL reprime_run: got %h, expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_boundary_clr();
        int waited = 0;
        logic [11:0] xi;
        logic [11:0] xq;
        reset_pulse();
        enable = 1'b1;
        rate_div = 16'd0;
        for (int n = 0; n < 8; n++) begin
            s_valid = 1'b1;
            s_data_i = (n == 0) ? 12'h7FF : 12'($urandom);
            s_data_q = (n == 0) ? 12'h800 : 12'($urandom);
            cycle();
        end
        s_valid = 1'b0;
        while (sample_strobe !== 1'b1 && waited < 10) begin
            cycle();
            waited++;
        end
        checks++;
        if (data_i !== 12'hFFF || data_q !== 12'h000) begin
            errors++;
            $display("[TB] FAIL extreme_values: got %h/%h, expected fff/000", data_i, data_q);
        end
        waited = 0;
        while (underflow !== 1'b1 && waited < 20) begin
            cycle();
            waited++;
        end
        clr_underflow = 1'b1;
        cycle();
        clr_underflow = 1'b0;
        checks++;
        if (underflow !== 1'b1 || underflow_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clr_on_event: got uf=%b cnt=%0d, expected uf=1 cnt=1", underflow, underflow_cnt);
        end
        xi = 12'($urandom);
        xq = 12'($urandom);
        s_valid = 1'b1;
        s_data_i = xi;
        s_data_q = xq;
        cycle();
        s_valid = 1'b0;
        checks++;
        if (underflow_cnt !== 16'd2 || fifo_level !== LW'(1) || sample_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL push_on_empty_tick: got cnt=%0d lvl=%0d stb=%b, expected 2/1/0", underflow_cnt, fifo_level, sample_strobe);
        end
        cycle();
        checks++;
        if (sample_strobe !== 1'b1 || data_i !== ob(xi) || data_q !== ob(xq)) begin
            errors++;
            $display("[TB] FAIL retained_push: got %b %h/%h, expected 1 %h/%h", sample_strobe, data_i, data_q, ob(xi), ob(xq));
        end
        rate_div = 16'd100;
        clr_underflow = 1'b1;
        cycle();
        clr_underflow = 1'b0;
        checks++;
        if (underflow !== 1'b0 || underflow_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clr_quiet: got uf=%b cnt=%0d, expected 0/0", underflow, underflow_cnt);
        end
    endtask

    task automatic test_random();
        reset_pulse();
        for (int cyc = 0; cyc < 800; cyc++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data_i = 12'($urandom);
            s_data_q = 12'($urandom);
            enable = ($urandom_range(0, 99) != 0);
            clr_underflow = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) rate_div = 16'($urandom_range(0, 4));
            #1;
            checks++;
            if (s_ready !== model_ready()) begin
                errors++;
                $display("[TB] FAIL rand_ready: got %b, expected %b", s_ready, model_ready());
            end
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("[TB] FAIL rand_model: got %h, expected %h", dut_vec, model_vec());
            end
        end
        s_valid = 1'b0;
        clr_underflow = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_saturation_reset();
        reset_pulse();
        enable = 1'b1;
        rate_div = 16'd0;
        for (int n = 0; n < 8; n++) begin
            s_valid = 1'b1;
            s_data_i = 12'($urandom);
            s_data_q = 12'($urandom);
            cycle();
        end
        s_valid = 1'b0;
        for (int n = 0; n < 14; n++) cycle();
        force dut.underflow_cnt = 16'hFFFE;
        #1;
        release dut.underflow_cnt;
        m_ufc = 65534;
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++;
            if (underflow_cnt !== 16'hFFFF || dut_vec !== model_vec()) begin
                errors++;
                $display("[TB] FAIL saturate: got %h, expected %h", dut_vec, model_vec());
            end
        end
        s_valid = 1'b1;
        s_data_i = 12'($urandom);
        s_data_q = 12'($urandom);
        reset = 1'b1;
        cycle();
        checks++;
        if (dut_vec !== {12'h800, 12'h800, 1'b0, LW'(0), 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL midstream_reset: got %h, expected %h", dut_vec, {12'h800, 12'h800, 1'b0, LW'(0), 1'b0, 1'b0, 16'd0});
        end
        reset = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prefill_playback();
        test_underflow_run();
        test_backpressure();
        test_enable_drop();
        test_boundary_clr();
        test_random();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
